mem_stage_sram_ctrl: RTL
========================

Name: mem_stage_sram_ctrl

Overview:
- Memory-access stage of the ARM pipeline. Sits between the EXE/MEM pipeline register and the MEM/WB stage register.
- Performs LDR/STR data accesses to an external 16-bit asynchronous SRAM, using two half-word transfers per 32-bit word.
- Drives `ready` low while an access is in flight. The hazard/freeze logic uses it to stall all upstream pipeline registers and to keep the MEM/WB register from loading.
- Supplies the 32-bit load value that the MEM/WB register captures as its memory read value.

Parameters:
- ADDR_BASE, 1024: byte address that maps to SRAM word 0. It is subtracted from `alu_result` before indexing.
- WAIT_CYCLES, 2: clock cycles held per half-word transfer. Legal range is 1 to 15.
- SRAM_AW, 18: width of the SRAM half-word address bus.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low. 0 resets the block.
- mem_r_en  in  1  load request from the EXE/MEM register.
- mem_w_en  in  1  store request from the EXE/MEM register.
- alu_result  in  32  effective byte address.
- st_val  in  32  store data (Rm value).
- ready  out  1  1 means the stage can advance; 0 means freeze the pipeline.
- read_data  out  32  completed load value.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 means the controller drives the data bus.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- States: IDLE, LO, HI, DONE. A wait counter `wcnt` (4 bits) runs within LO and HI.
- Reset (rst=0, asynchronous) gives:
  - state=IDLE, wcnt=0, read_data=0, latched registers=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Reset mid-access aborts the access immediately. No completion pulse is produced and read_data returns to 0.
- ready (combinational):
  - In IDLE: 1 when mem_r_en=0 and mem_w_en=0, else 0.
  - In LO and HI: 0.
  - In DONE: 1.
  - With rst=0 and no request, ready=1.
- IDLE to LO, when mem_r_en or mem_w_en is 1 at the clock edge:
  - Latch op, `st_val`, and `widx = (alu_result - ADDR_BASE) >> 2`. The subtraction is 32-bit unsigned and wraps; there is no range error.
  - Clear wcnt.
  - If both enables are 1, the access is a store and read_data is unchanged.
- LO:
  - sram_addr = {widx, 1'b0}, truncated to SRAM_AW. Store: sram_dq_out = st_val[15:0].
  - wcnt increments each cycle. On the cycle where wcnt = WAIT_CYCLES-1, a load captures sram_dq_in into rd_lo; then clear wcnt and go to HI.
- HI:
  - sram_addr = {widx, 1'b1}, truncated to SRAM_AW. Store: sram_dq_out = st_val[31:16].
  - Same wcnt rule as LO. On the final cycle a load writes read_data = {sram_dq_in, rd_lo}; then go to DONE.
- Store accesses: sram_we_n=0 and sram_dq_oe=1 for every LO and HI cycle.
- Load accesses: sram_we_n=1 and sram_dq_oe=0 throughout.
- DONE:
  - Lasts exactly one cycle, with ready=1, then goes to IDLE unconditionally.
  - The pipeline advances on this edge, so the request inputs seen in the next IDLE cycle belong to the next instruction.
- Outside LO and HI: sram_addr=0, sram_we_n=1, sram_dq_oe=0.
- Latency: a request first presented in IDLE during cycle t gives ready=1 in cycle t+2·WAIT_CYCLES+1. With the default (2), that is t+5. The stall lasts 2·WAIT_CYCLES+1 cycles.
- Inputs that change during LO or HI are ignored; the latched values are used.
- Back-to-back accesses: the earliest next access starts on the IDLE-to-LO edge following DONE. There is one IDLE cycle, with ready=0, between consecutive accesses.
- read_data holds the last completed load value through stores, idle time and stalls.

Test Plan:
- Reset and idle: hold rst=0 with no request. Expect ready=1, read_data=0, sram_we_n=1, sram_dq_oe=0. Release rst; the outputs are unchanged.
- Store: mem_w_en=1, alu_result=1032, st_val=0xDEADBEEF.
  - Cycles 1–2: sram_addr=4, dq_out=0xBEEF, we_n=0.
  - Cycles 3–4: sram_addr=5, dq_out=0xDEAD.
  - Cycle 5 (DONE): ready=1. ready was 0 in cycles 0–4.
- Load: the SRAM model returns 0x1234 at address 4 and 0x5678 at address 5; apply mem_r_en=1, alu_result=1032. Expect read_data=0x56781234 in the DONE cycle, held afterwards, with we_n=1 throughout.
- Back-to-back and simultaneous:
  - Store then load to the same address: read-back equals the stored word, and one ready=0 IDLE cycle separates the two accesses.
  - mem_r_en=mem_w_en=1: the access performs a store and leaves read_data unchanged.
- Reset mid-access: assert rst=0 during HI of a load. State goes to IDLE immediately, read_data=0, and ready=1 once the requests are low.
- Parameter sweep: WAIT_CYCLES=1 gives ready after 3 cycles. WAIT_CYCLES=4 gives ready after 9 cycles. alu_result=1020 wraps: widx=0x3FFFFFFF, so sram_addr is all-ones in HI and all-ones minus 1 in LO.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sram_ctrl
// Brief    : MEM stage; 32-bit LDR/STR as two half-word async SRAM transfers.
// Revision : 1.0
// ============================================================================
module mem_stage_sram_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        st_val,
    output logic               ready,
    output logic [31:0]        read_data,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] C_WLAST = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wcnt;
    logic        r_is_store;
    logic [31:0] r_st_val;
    logic [29:0] r_widx;
    logic [15:0] r_rd_lo;
    logic [31:0] r_read_data;
    logic        w_req;
    logic        w_last;

    assign w_req     = mem_r_en | mem_w_en;
    assign w_last    = (r_wcnt == C_WLAST);
    assign read_data = r_read_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req)  w_state_nxt = S_LO;
            S_LO:    if (w_last) w_state_nxt = S_HI;
            S_HI:    if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields are latched once so upstream changes during the stall are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt      <= 4'd0;
            r_is_store  <= 1'b0;
            r_st_val    <= 32'd0;
            r_widx      <= 30'd0;
            r_rd_lo     <= 16'd0;
            r_read_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_store <= mem_w_en;
                        r_st_val   <= st_val;
                        r_widx     <= 30'((alu_result - 32'(ADDR_BASE)) >> 2);
                        r_wcnt     <= 4'd0;
                    end
                end
                S_LO: begin
                    r_wcnt <= w_last ? 4'd0 : r_wcnt + 4'd1;
                    if (w_last && !r_is_store) begin
                        r_rd_lo <= sram_dq_in;
                    end
                end
                S_HI: begin
                    r_wcnt <= w_last ? 4'd0 : r_wcnt + 4'd1;
                    if (w_last && !r_is_store) begin
                        r_read_data <= {sram_dq_in, r_rd_lo};
                    end
                end
                default: r_wcnt <= 4'd0;
            endcase
        end
    end

    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (r_state)
            S_IDLE: ready = ~w_req;
            S_LO: begin
                sram_addr   = SRAM_AW'({r_widx, 1'b0});
                sram_dq_out = r_is_store ? r_st_val[15:0] : 16'd0;
                sram_dq_oe  = r_is_store;
                sram_we_n   = ~r_is_store;
            end
            S_HI: begin
                sram_addr   = SRAM_AW'({r_widx, 1'b1});
                sram_dq_out = r_is_store ? r_st_val[31:16] : 16'd0;
                sram_dq_oe  = r_is_store;
                sram_we_n   = ~r_is_store;
            end
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule
`default_nettype wire
